// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master drives requests and consumes results; the slave is the encoder.
interface instr_encoder_if #(
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         imm;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         instr;
    logic [31:0]         out_addr;
    logic [2:0]          err;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, flush, out_ready,
        input  in_ready, out_valid, instr, out_addr, err, err_count
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, flush, out_ready,
        output in_ready, out_valid, instr, out_addr, err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I encoder: stage 1 captures fields and classifies the
// format, stage 2 holds the packed word, error flags and its assigned byte address.
module instr_encoder #(
    parameter int ERRCNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD
    } fmt_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic fmt_t classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011, 7'b1100111: return FMT_I;
            7'b0010011:             return (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            7'b0100011:             return FMT_S;
            7'b1100011:             return FMT_B;
            7'b1101111:             return FMT_J;
            7'b0110111, 7'b0010111: return FMT_U;
            7'b0110011:             return FMT_R;
            default:                return FMT_BAD;
        endcase
    endfunction

    // True when v is representable as a signed value of the given bit width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = 32'hFFFF_FFFF << (bits - 1);
        return ((v & hi) == 32'd0) || ((v & hi) == hi);
    endfunction

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                r_rdy_en;
    logic                r_vld_p1;
    fmt_t                r_fmt_p1;
    logic [6:0]          r_opcode_p1;
    logic [2:0]          r_funct3_p1;
    logic [6:0]          r_funct7_p1;
    logic [4:0]          r_rd_p1;
    logic [4:0]          r_rs1_p1;
    logic [4:0]          r_rs2_p1;
    logic [31:0]         r_imm_p1;
    logic                r_vld_p2;
    logic [31:0]         r_instr_p2;
    logic [2:0]          r_err_p2;
    logic [31:0]         r_addr;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic                w_s2_en;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_deliver;
    logic [31:0]         w_instr;
    logic [2:0]          w_err;

    assign w_s2_en    = !r_vld_p2 || bus.out_ready;
    assign w_in_ready = r_rdy_en && !bus.flush && (!r_vld_p1 || w_s2_en);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_deliver  = r_vld_p2 && bus.out_ready;

    // Control: stage valids, ready enable and the delivery counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_addr    <= 32'd0;
            r_err_cnt <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (bus.flush) begin
                r_vld_p1 <= 1'b0;
                r_vld_p2 <= 1'b0;
            end else begin
                if (w_s2_en)    r_vld_p2 <= r_vld_p1;
                if (w_in_ready) r_vld_p1 <= bus.in_valid;
            end
            if (w_deliver) begin
                r_addr <= r_addr + 32'd4;
                if (|r_err_p2) r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    // Stage 1: capture request fields and classify the format.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fmt_p1    <= classify(bus.opcode, bus.funct3);
            r_opcode_p1 <= bus.opcode;
            r_funct3_p1 <= bus.funct3;
            r_funct7_p1 <= bus.funct7;
            r_rd_p1     <= bus.rd;
            r_rs1_p1    <= bus.rs1;
            r_rs2_p1    <= bus.rs2;
            r_imm_p1    <= bus.imm;
        end
    end

    // Errored requests still produce the truncated encoding of their format.
    always_comb begin
        w_instr = NOP;
        w_err   = 3'b000;
        case (r_fmt_p1)
            FMT_I: begin
                w_instr  = {r_imm_p1[11:0], r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
                w_err[0] = !fits_signed(r_imm_p1, 12);
            end
            FMT_SH: begin
                w_instr  = {r_funct7_p1, r_imm_p1[4:0], r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
                w_err[0] = |r_imm_p1[31:5];
            end
            FMT_S: begin
                w_instr  = {r_imm_p1[11:5], r_rs2_p1, r_rs1_p1, r_funct3_p1, r_imm_p1[4:0], r_opcode_p1};
                w_err[0] = !fits_signed(r_imm_p1, 12);
            end
            FMT_B: begin
                w_instr  = {r_imm_p1[12], r_imm_p1[10:5], r_rs2_p1, r_rs1_p1, r_funct3_p1,
                            r_imm_p1[4:1], r_imm_p1[11], r_opcode_p1};
                w_err[0] = !fits_signed(r_imm_p1, 13);
                w_err[1] = r_imm_p1[0];
            end
            FMT_J: begin
                w_instr  = {r_imm_p1[20], r_imm_p1[10:1], r_imm_p1[11], r_imm_p1[19:12],
                            r_rd_p1, r_opcode_p1};
                w_err[0] = !fits_signed(r_imm_p1, 21);
                w_err[1] = r_imm_p1[0];
            end
            FMT_U: begin
                w_instr  = {r_imm_p1[31:12], r_rd_p1, r_opcode_p1};
                w_err[0] = |r_imm_p1[11:0];
            end
            FMT_R: begin
                w_instr  = {r_funct7_p1, r_rs2_p1, r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
            end
            default: begin
                w_err[2] = 1'b1;
            end
        endcase
    end

    // Stage 2: packed word and flags, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_p2 <= 32'd0;
            r_err_p2   <= 3'b000;
        end else if (w_s2_en && r_vld_p1) begin
            r_instr_p2 <= w_instr;
            r_err_p2   <= w_err;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p2;
    assign bus.instr     = r_instr_p2;
    assign bus.out_addr  = r_addr;
    assign bus.err       = r_err_p2;
    assign bus.err_count = r_err_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table of encodings plus hand-written
// backpressure, flush and reset sequences.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if #(.ERRCNT_W(8)) bus ();
    instr_encoder #(.ERRCNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t        vt [0:16];
    int          n_pass = 0;
    int          n_chk  = 0;
    logic [31:0] m_addr;
    int          m_cnt;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] ei, input logic [2:0] ee);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.opcode = v.op; bus.funct3 = v.f3; bus.funct7 = v.f7;
        bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2; bus.imm = v.imm;
    endtask

    task automatic model_deliver(input logic [2:0] e);
        m_addr = m_addr + 32'd4;
        if (e != 3'b000 && m_cnt < 255) m_cnt++;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_addr = 32'd0;
        m_cnt  = 0;
    endtask

    // One request with out_ready high: checks latency, encoding, address and count.
    task automatic run_vec(input vec_t v, input string name);
        int t;
        @(negedge clk);
        drive(v);
        t = 0;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk({name, " accept_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({name, " lat1_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk({name, " lat2_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({name, " instr"}, bus.instr, v.exp_instr);
        chk({name, " err"}, {29'd0, bus.err}, {29'd0, v.exp_err});
        chk({name, " addr"}, bus.out_addr, m_addr);
        model_deliver(v.exp_err);
        @(negedge clk);
        chk({name, " err_count"}, {24'd0, bus.err_count}, m_cnt);
    endtask

    initial begin
        int sent;
        int got;
        int bp [0:2];
        vt[0]  = mk(7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 3'b000);
        vt[1]  = mk(7'h63, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 3'b000);
        vt[2]  = mk(7'h37, 3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 3'b000);
        vt[3]  = mk(7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,      32'h8000_0093, 3'b001);
        vt[4]  = mk(7'h63, 3'd1, 7'd0,  5'd0, 5'd1, 5'd2, 32'd3,         32'h0020_9163, 3'b010);
        vt[5]  = mk(7'h7F, 3'd0, 7'd0,  5'd1, 5'd2, 5'd3, 32'd0,         32'h0000_0013, 3'b100);
        vt[6]  = mk(7'h23, 3'd2, 7'd0,  5'd0, 5'd2, 5'd3, 32'hFFFF_FFF8, 32'hFE31_2C23, 3'b000);
        vt[7]  = mk(7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 3'b000);
        vt[8]  = mk(7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0000_0801, 32'h0010_00EF, 3'b010);
        vt[9]  = mk(7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h8000_00EF, 3'b001);
        vt[10] = mk(7'h13, 3'd1, 7'd0,  5'd3, 5'd4, 5'd0, 32'd5,         32'h0052_1193, 3'b000);
        vt[11] = mk(7'h13, 3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 32'd32,        32'h4002_5193, 3'b001);
        vt[12] = mk(7'h33, 3'd0, 7'd0,  5'd5, 5'd6, 5'd7, 32'hDEAD_BEEF, 32'h0073_02B3, 3'b000);
        vt[13] = mk(7'h17, 3'd0, 7'd0,  5'd2, 5'd0, 5'd0, 32'h0000_1001, 32'h0000_1117, 3'b001);
        vt[14] = mk(7'h03, 3'd2, 7'd0,  5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 32'h8001_2083, 3'b000);
        vt[15] = mk(7'h67, 3'd0, 7'd0,  5'd0, 5'd1, 5'd0, 32'h0000_07FF, 32'h7FF0_8067, 3'b000);
        vt[16] = mk(7'h63, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'h0000_1000, 32'h8020_8063, 3'b001);
        bp[0] = 0; bp[1] = 6; bp[2] = 2;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
        bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
        m_addr = 32'd0;
        m_cnt  = 0;

        // Reset state and ready release on the first edge after reset.
        repeat (2) @(negedge clk);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst instr",     bus.instr,              32'd0);
        chk("rst out_addr",  bus.out_addr,           32'd0);
        chk("rst err_count", {24'd0, bus.err_count}, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel in_ready pre_edge", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("rel in_ready post_edge", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i <= 16; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset asserted mid-stream while an output is pending.
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(vt[1]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid pending out_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("mid instr",     bus.instr,              32'd0);
        chk("mid err",       {29'd0, bus.err},       32'd0);
        chk("mid out_addr",  bus.out_addr,           32'd0);
        chk("mid err_count", {24'd0, bus.err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid rel in_ready pre_edge", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        m_addr = 32'd0;
        m_cnt  = 0;
        run_vec(vt[2], "post_rst");

        // Backpressure: three offered back-to-back against a stalled consumer.
        do_reset();
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("bp stall%0d valid", c), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("bp stall%0d instr", c), bus.instr, vt[bp[0]].exp_instr);
            end
            if (sent < 3) drive(vt[bp[sent]]);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        @(negedge clk);
        chk("bp accepted", sent, 32'd2);
        chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (bus.out_valid) begin
                chk($sformatf("bp out%0d instr", got), bus.instr, vt[bp[got]].exp_instr);
                chk($sformatf("bp out%0d addr", got), bus.out_addr, m_addr);
                model_deliver(vt[bp[got]].exp_err);
                got++;
            end
            if (sent < 3) drive(vt[bp[sent]]);
            else bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("bp outputs", got, 32'd3);

        // Flush with both stages full; in_valid during flush is ignored.
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            @(negedge clk);
            drive(sent == 0 ? vt[3] : vt[1]);
            if (bus.in_ready) sent++;
        end
        @(negedge clk);
        chk("fl full out_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(vt[4]);
        bus.flush = 1'b1;
        #1 chk("fl in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl out_addr", bus.out_addr, m_addr);
        chk("fl err_count", {24'd0, bus.err_count}, m_cnt);
        @(negedge clk);
        chk("fl ignored req", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        run_vec(vt[5], "post_flush");

        // Flush coinciding with an output handshake still counts the delivery.
        @(negedge clk);
        drive(vt[8]);
        chk("flhs accept0", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        drive(vt[7]);
        chk("flhs accept1", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("flhs instr", bus.instr, vt[8].exp_instr);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_deliver(vt[8].exp_err);
        chk("flhs out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flhs out_addr", bus.out_addr, m_addr);
        chk("flhs err_count", {24'd0, bus.err_count}, m_cnt);
        @(negedge clk);
        chk("flhs dropped s1", {31'd0, bus.out_valid}, 32'd0);

        // Stream of bad opcodes drives the error counter into saturation.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 700 && got < 260; c++) begin
            if (bus.out_valid) begin
                model_deliver(bus.err == 3'b100 ? 3'b100 : 3'b000);
                got++;
            end
            if (sent < 260) drive(vt[5]);
            else bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("sat outputs", got, 32'd260);
        chk("sat err_count", {24'd0, bus.err_count}, 32'd255);
        chk("sat model count", m_cnt, 32'd255);
        chk("sat out_addr", bus.out_addr, m_addr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ERRCNT_W, default 8, width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, request fields are valid.
REQ-005 SHALL have port in_ready, output, 1, encoder accepts a request this cycle.
REQ-006 SHALL have ports opcode (7), funct3 (3), funct7 (7), rd (5), rs1 (5), rs2 (5), all inputs: the RV32I instruction fields.
REQ-007 SHALL have port imm, input, 32, the full signed immediate or byte offset.
REQ-008 SHALL have port flush, input, 1, synchronous pipeline clear.
REQ-009 SHALL have port out_valid, output, 1, instr, out_addr and err are valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the output.
REQ-011 SHALL have port instr, output, 32, the encoded instruction word.
REQ-012 SHALL have port out_addr, output, 32, the byte address assigned to instr.
REQ-013 SHALL have port err, output, 3, the error flags {bad_opcode, misaligned, range}.
REQ-014 SHALL have port err_count, output, ERRCNT_W, the number of outputs delivered with nonzero err.

Function
REQ-015 SHALL be a 2-stage valid/ready pipeline: S1 registers the fields and classifies the format; S2 registers the packed instr and err.
REQ-016 SHALL accept a request when in_valid && in_ready, and SHALL deliver an output when out_valid && out_ready.
REQ-017 SHALL drive in_ready = !flush && (!s1_valid || !out_valid || out_ready), giving 1 accept per cycle when there is no backpressure.
REQ-018 SHALL raise out_valid exactly 2 cycles after acceptance when there is no stall; SHALL hold instr, out_addr and err stable while out_valid && !out_ready.
REQ-019 SHALL never drop, duplicate or reorder requests under any out_ready pattern.
REQ-020 SHALL encode I-type (load 0000011, ALU-imm 0010011, JALR 1100111) as {imm[11:0],rs1,funct3,rd,opcode}; range error if imm[31:11] is not all-equal.
REQ-021 SHALL encode ALU-imm shifts (funct3 001/101) as {funct7,imm[4:0],rs1,funct3,rd,opcode}; range error if imm[31:5] != 0.
REQ-022 SHALL encode S-type 0100011 as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; range check signed 12-bit.
REQ-023 SHALL encode B-type 1100011 as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; range error if not signed 13-bit; misaligned if imm[0]=1.
REQ-024 SHALL encode J-type 1101111 as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; range error if not signed 21-bit; misaligned if imm[0]=1.
REQ-025 SHALL encode U-type 0110111/0010111 as {imm[31:12],rd,opcode}; range error if imm[11:0] != 0.
REQ-026 SHALL encode R-type 0110011 as {funct7,rs2,rs1,funct3,rd,opcode}, with no immediate checks.
REQ-027 SHALL, for any other opcode, set bad_opcode, clear the other err bits and output instr = 32'h00000013.
REQ-028 SHALL, for range or misaligned errors, still output the truncated encoding per the format rules.
REQ-029 SHALL increment out_addr by 4 on every output handshake, including errored outputs; 0xFFFFFFFC SHALL wrap to 0.
REQ-030 SHALL increment err_count on each output handshake with err != 0, saturating at all-ones.
REQ-031 SHALL, on flush, clear both stage valids at the next edge; in_valid in that cycle SHALL be ignored; out_addr and err_count SHALL be unchanged.
REQ-032 SHALL give flush priority when it coincides with an output handshake: the output counts as delivered and the counters update.

Reset
REQ-033 SHALL, while rst_n is low, immediately force out_valid=0, in_ready=0, instr=0, err=0, out_addr=0, err_count=0 and both stage valids to 0.
REQ-034 SHALL discard any in-flight requests when reset is asserted mid-operation; in_ready SHALL rise on the first clk edge after rst_n goes high.

Verification
REQ-035 SHALL pass: ADDI rd=1, rs1=0, imm=0xFFFFFFFF -> instr=0xFFF00093, err=0, out_valid 2 cycles after accept, out_addr=0.
REQ-036 SHALL pass: BEQ rs1=1, rs2=2, imm=0xFFFFFFFC -> instr=0xFE208EE3; then LUI rd=5, imm=0x12345000 -> instr=0x123452B7 at out_addr=4.
REQ-037 SHALL pass: ADDI imm=2048 -> err=3'b001, err_count=1; BNE imm=3 -> err=3'b010, err_count=2; opcode 0x7F -> err=3'b100, instr=0x00000013.
REQ-038 SHALL pass: with out_ready=0 for 6 cycles and 3 requests offered back-to-back -> exactly 2 accepted, then in_ready=0; after release, outputs appear in order at out_addr 0, 4, 8.
REQ-039 SHALL pass: flush with both stages full -> out_valid=0 next cycle, out_addr and err_count unchanged, and the next accept is delivered 2 cycles later.
REQ-040 SHALL pass: rst_n low mid-stream with out_valid=1 -> all outputs 0 without a clock edge; the first request after release gets out_addr=0.
